// File: rtl/median_window_3x3.sv
// 3x3 window generator for the median filter: two line buffers plus a shifting
// 3x3 register window over a raster pixel stream, valid/ready on both sides.
`timescale 1ns/1ps

module median_window_3x3 #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 16,
    parameter int IMG_H  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_pixel,
    input  logic              in_sof,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] w0,
    output logic [DATA_W-1:0] w1,
    output logic [DATA_W-1:0] w2,
    output logic [DATA_W-1:0] w3,
    output logic [DATA_W-1:0] w4,
    output logic [DATA_W-1:0] w5,
    output logic [DATA_W-1:0] w6,
    output logic [DATA_W-1:0] w7,
    output logic [DATA_W-1:0] w8
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] win_q [0:8];
    logic [DATA_W-1:0] win_d [0:8];

    logic [DATA_W-1:0] lb0_q [0:IMG_W-1];
    logic [DATA_W-1:0] lb1_q [0:IMG_W-1];

    logic              in_ready_s;
    logic              accept_s;
    logic [CW-1:0]     cur_col_s;
    logic [RW-1:0]     cur_row_s;
    logic [DATA_W-1:0] top_s;
    logic [DATA_W-1:0] mid_s;

    // Handshake and effective position of the current pixel (in_sof forces origin)
    always_comb begin
        in_ready_s = ~out_valid_q | out_ready;
        accept_s   = in_valid & in_ready_s;
        if (in_sof) begin
            cur_col_s = '0;
            cur_row_s = '0;
        end else begin
            cur_col_s = col_q;
            cur_row_s = row_q;
        end
        top_s = lb1_q[cur_col_s];
        mid_s = lb0_q[cur_col_s];
    end

    // Raster position counters, advanced from the effective position on accept
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept_s) begin
            if (cur_col_s == COL_LAST) begin
                col_d = '0;
                if (cur_row_s == ROW_LAST) begin
                    row_d = '0;
                end else begin
                    row_d = cur_row_s + RW'(1);
                end
            end else begin
                col_d = cur_col_s + CW'(1);
                row_d = cur_row_s;
            end
        end else begin
            col_d = col_q;
            row_d = row_q;
        end
    end

    // Window shift and output-valid update
    always_comb begin
        for (int i = 0; i < 9; i++) begin
            win_d[i] = win_q[i];
        end
        out_valid_d = out_valid_q;
        if (accept_s) begin
            win_d[0] = win_q[1];
            win_d[1] = win_q[2];
            win_d[2] = top_s;
            win_d[3] = win_q[4];
            win_d[4] = win_q[5];
            win_d[5] = mid_s;
            win_d[6] = win_q[7];
            win_d[7] = win_q[8];
            win_d[8] = in_pixel;
            out_valid_d = (cur_row_s >= ROW_TWO) && (cur_col_s >= COL_TWO);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Control and window registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q       <= '0;
            row_q       <= '0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            out_valid_q <= out_valid_d;
            for (int i = 0; i < 9; i++) begin
                win_q[i] <= win_d[i];
            end
        end
    end

    // Line buffers: not reset, the row counter decides when their contents matter;
    // the read above sees the old word, so lb1 receives what lb0 held before this write
    always_ff @(posedge clk) begin
        if (accept_s) begin
            lb1_q[cur_col_s] <= lb0_q[cur_col_s];
            lb0_q[cur_col_s] <= in_pixel;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_q;
    assign w0 = win_q[0];
    assign w1 = win_q[1];
    assign w2 = win_q[2];
    assign w3 = win_q[3];
    assign w4 = win_q[4];
    assign w5 = win_q[5];
    assign w6 = win_q[6];
    assign w7 = win_q[7];
    assign w8 = win_q[8];

endmodule

// File: tb/tb_median_window_3x3.sv
// Directed bench for median_window_3x3 on a 4x4 image streaming pixels 1..16.
`timescale 1ns/1ps

module tb_median_window_3x3;

    localparam int DW = 8;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_pixel;
    logic          in_sof;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] w0, w1, w2, w3, w4, w5, w6, w7, w8;
    logic [9*DW-1:0] win;

    int n_vec;
    int n_err;
    int valid_cycles;
    bit send_timeout;
    logic [9*DW-1:0] cap_q [$];
    logic [9*DW-1:0] exp_w [4];

    median_window_3x3 #(.DATA_W(DW), .IMG_W(4), .IMG_H(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel), .in_sof(in_sof),
        .out_valid(out_valid), .out_ready(out_ready),
        .w0(w0), .w1(w1), .w2(w2), .w3(w3), .w4(w4), .w5(w5), .w6(w6), .w7(w7), .w8(w8)
    );

    assign win = {w0, w1, w2, w3, w4, w5, w6, w7, w8};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every consumed window and every cycle out_valid is high
    always @(posedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) cap_q.push_back(win);
            if (out_valid) valid_cycles <= valid_cycles + 1;
        end
    end

    // Drive one pixel starting at a negedge, wait for it to be accepted, return at the next negedge
    task automatic send(input int p, input bit s);
        int guard;
        logic [31:0] pv;
        pv = p;
        in_valid = 1'b1;
        in_pixel = pv[DW-1:0];
        in_sof   = s;
        #1;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (guard >= 100) send_timeout = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic stream(input int first, input int last, input bit sof_first);
        for (int p = first; p <= last; p++) send(p, sof_first && (p == first));
    endtask

    task automatic test_reset;
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (out_valid !== 1'b0) begin $display("FAIL reset_out_valid: got %b expected 0", out_valid); n_err++; end
        n_vec++;
        if (win !== '0) begin $display("FAIL reset_window: got %h expected 0", win); n_err++; end
        n_vec++;
        if (in_ready !== 1'b1) begin $display("FAIL reset_in_ready: got %b expected 1", in_ready); n_err++; end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Test 1: cycle-exact latency and window contents
    task automatic test_stream;
        int idx;
        bit exp_v;
        for (int p = 1; p <= 16; p++) begin
            in_valid = 1'b1;
            in_pixel = DW'(p);
            in_sof   = (p == 1);
            @(posedge clk);
            #1;
            exp_v = (p == 11) || (p == 12) || (p == 15) || (p == 16);
            idx = (p == 11) ? 0 : (p == 12) ? 1 : (p == 15) ? 2 : 3;
            n_vec++;
            if (out_valid !== exp_v) begin
                $display("FAIL stream_valid p%0d: got %b expected %b", p, out_valid, exp_v); n_err++;
            end
            if (exp_v) begin
                n_vec++;
                if (win !== exp_w[idx]) begin
                    $display("FAIL stream_window p%0d: got %h expected %h", p, win, exp_w[idx]); n_err++;
                end
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
        @(posedge clk);
        #1;
        n_vec++;
        if (out_valid !== 1'b0) begin $display("FAIL stream_drop: got %b expected 0", out_valid); n_err++; end
        @(negedge clk);
    endtask

    // Test 2: downstream stall after the first window
    task automatic test_backpressure;
        int base;
        base = cap_q.size();
        send_timeout = 1'b0;
        stream(1, 11, 1'b1);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_pixel  = DW'(12);
        in_sof    = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_vec++;
            if (in_ready !== 1'b0) begin $display("FAIL stall_in_ready c%0d: got %b expected 0", k, in_ready); n_err++; end
            n_vec++;
            if (out_valid !== 1'b1 || win !== exp_w[0]) begin
                $display("FAIL stall_hold c%0d: got v=%b %h expected v=1 %h", k, out_valid, win, exp_w[0]); n_err++;
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        stream(12, 16, 1'b0);
        repeat (2) @(negedge clk);
        n_vec++;
        if (cap_q.size() - base !== 4) begin $display("FAIL stall_count: got %0d expected 4", cap_q.size() - base); n_err++; end
        for (int k = 0; k < 4; k++) begin
            n_vec++;
            if (cap_q.size() <= base + k || cap_q[base + k] !== exp_w[k]) begin
                $display("FAIL stall_window%0d: got %h expected %h", k, (cap_q.size() > base + k) ? cap_q[base + k] : '0, exp_w[k]); n_err++;
            end
        end
        n_vec++;
        if (send_timeout !== 1'b0) begin $display("FAIL stall_timeout: got 1 expected 0"); n_err++; end
    endtask

    // Test 3: two frames without a gap
    task automatic test_back_to_back;
        int base;
        base = cap_q.size();
        send_timeout = 1'b0;
        stream(1, 16, 1'b1);
        stream(1, 16, 1'b1);
        repeat (2) @(negedge clk);
        n_vec++;
        if (cap_q.size() - base !== 8) begin $display("FAIL b2b_count: got %0d expected 8", cap_q.size() - base); n_err++; end
        for (int k = 0; k < 8; k++) begin
            n_vec++;
            if (cap_q.size() <= base + k || cap_q[base + k] !== exp_w[k % 4]) begin
                $display("FAIL b2b_window%0d: got %h expected %h", k, (cap_q.size() > base + k) ? cap_q[base + k] : '0, exp_w[k % 4]); n_err++;
            end
        end
        n_vec++;
        if (send_timeout !== 1'b0) begin $display("FAIL b2b_timeout: got 1 expected 0"); n_err++; end
    endtask

    // Test 4: partial frame abandoned by a new start of frame
    task automatic test_resync;
        int base;
        base = cap_q.size();
        send_timeout = 1'b0;
        stream(1, 10, 1'b1);
        stream(1, 16, 1'b1);
        repeat (2) @(negedge clk);
        n_vec++;
        if (cap_q.size() - base !== 4) begin $display("FAIL resync_count: got %0d expected 4", cap_q.size() - base); n_err++; end
        for (int k = 0; k < 4; k++) begin
            n_vec++;
            if (cap_q.size() <= base + k || cap_q[base + k] !== exp_w[k]) begin
                $display("FAIL resync_window%0d: got %h expected %h", k, (cap_q.size() > base + k) ? cap_q[base + k] : '0, exp_w[k]); n_err++;
            end
        end
        n_vec++;
        if (send_timeout !== 1'b0) begin $display("FAIL resync_timeout: got 1 expected 0"); n_err++; end
    endtask

    // Test 5: reset mid-frame, then restream without in_sof
    task automatic test_midframe_reset;
        int base;
        send_timeout = 1'b0;
        stream(1, 9, 1'b1);
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (out_valid !== 1'b0) begin $display("FAIL mreset_out_valid: got %b expected 0", out_valid); n_err++; end
        n_vec++;
        if (win !== '0) begin $display("FAIL mreset_window: got %h expected 0", win); n_err++; end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        base = cap_q.size();
        stream(1, 16, 1'b0);
        repeat (2) @(negedge clk);
        n_vec++;
        if (cap_q.size() - base !== 4) begin $display("FAIL mreset_count: got %0d expected 4", cap_q.size() - base); n_err++; end
        for (int k = 0; k < 4; k++) begin
            n_vec++;
            if (cap_q.size() <= base + k || cap_q[base + k] !== exp_w[k]) begin
                $display("FAIL mreset_window%0d: got %h expected %h", k, (cap_q.size() > base + k) ? cap_q[base + k] : '0, exp_w[k]); n_err++;
            end
        end
        n_vec++;
        if (send_timeout !== 1'b0) begin $display("FAIL mreset_timeout: got 1 expected 0"); n_err++; end
    endtask

    // Test 6: in_valid alternating with idle cycles
    task automatic test_bubbles;
        int base;
        int vbase;
        base  = cap_q.size();
        vbase = valid_cycles;
        send_timeout = 1'b0;
        for (int p = 1; p <= 16; p++) begin
            send(p, p == 1);
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        n_vec++;
        if (cap_q.size() - base !== 4) begin $display("FAIL bubble_count: got %0d expected 4", cap_q.size() - base); n_err++; end
        for (int k = 0; k < 4; k++) begin
            n_vec++;
            if (cap_q.size() <= base + k || cap_q[base + k] !== exp_w[k]) begin
                $display("FAIL bubble_window%0d: got %h expected %h", k, (cap_q.size() > base + k) ? cap_q[base + k] : '0, exp_w[k]); n_err++;
            end
        end
        n_vec++;
        if (valid_cycles - vbase !== 4) begin $display("FAIL bubble_valid_cycles: got %0d expected 4", valid_cycles - vbase); n_err++; end
        n_vec++;
        if (send_timeout !== 1'b0) begin $display("FAIL bubble_timeout: got 1 expected 0"); n_err++; end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        valid_cycles = 0;
        send_timeout = 1'b0;
        exp_w[0] = {8'd1, 8'd2, 8'd3, 8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11};
        exp_w[1] = {8'd2, 8'd3, 8'd4, 8'd6, 8'd7, 8'd8, 8'd10, 8'd11, 8'd12};
        exp_w[2] = {8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11, 8'd13, 8'd14, 8'd15};
        exp_w[3] = {8'd6, 8'd7, 8'd8, 8'd10, 8'd11, 8'd12, 8'd14, 8'd15, 8'd16};
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_pixel  = '0;
        in_sof    = 1'b0;
        out_ready = 1'b1;

        test_reset;
        test_stream;
        repeat (2) @(negedge clk);
        test_backpressure;
        test_back_to_back;
        test_resync;
        test_midframe_reset;
        test_bubbles;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
